// File: rtl/avalon_st_pkg.sv
// avalon_st_pkg: shared FSM encoding and default frame length limit for the Avalon-ST frame guard
package avalon_st_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IN_FRAME,
        ST_DROP
    } guard_state_e;

    localparam int MAX_BEATS_DEFAULT = 150;

endpackage

// File: rtl/avalon_st_pipe_reg.sv
// avalon_st_pipe_reg: single registered ready/valid stage, full throughput, payload held under backpressure
module avalon_st_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_payload
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] payload_q, payload_d;

    always_comb begin
        in_ready  = !valid_q || out_ready;
        valid_d   = in_ready ? in_valid : valid_q;
        payload_d = (in_ready && in_valid) ? in_payload : payload_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;

endmodule

// File: rtl/avalon_st_frame_guard.sv
// avalon_st_frame_guard: drops orphan beats, force-terminates overlong or sop-interrupted frames, counts outcomes
module avalon_st_frame_guard
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6,
    parameter int MAX_BEATS   = MAX_BEATS_DEFAULT,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_error,
    input  logic                   out_ready,
    input  logic                   cnt_clear,
    output logic [CNT_WIDTH-1:0]   cnt_good,
    output logic [CNT_WIDTH-1:0]   cnt_err,
    output logic [CNT_WIDTH-1:0]   cnt_drop
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int PW = DATA_WIDTH + EMPTY_WIDTH + 3;

    guard_state_e         state_q, state_d;
    logic [BW-1:0]        count_q, count_d;
    logic [CNT_WIDTH-1:0] good_q, good_d, err_q, err_d, drop_q, drop_d;
    logic                 accept, fwd, term, last_beat;
    logic                 inc_good, inc_err, inc_drop;
    logic                 o_sop, o_eop, o_err;
    logic [EMPTY_WIDTH-1:0] o_empty;
    logic [PW-1:0]        pipe_out;

    assign accept    = in_valid && in_ready;
    assign last_beat = count_q == BW'(MAX_BEATS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            good_q  <= '0;
            err_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            good_q  <= good_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: if (in_sop && !in_eop) begin
                    state_d = ST_IN_FRAME;
                    count_d = BW'(1);
                end
                ST_IN_FRAME: if (in_sop || in_eop || last_beat) state_d = in_eop ? ST_IDLE : ST_DROP;
                             else count_d = count_q + BW'(1);
                ST_DROP: if (in_eop) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // term covers both forced terminations: length limit reached, or a new sop inside an open frame
    always_comb begin
        fwd      = accept && (state_q == ST_IN_FRAME || (state_q == ST_IDLE && in_sop));
        term     = accept && state_q == ST_IN_FRAME && (in_sop || (!in_eop && last_beat));
        inc_good = fwd && in_eop && !term;
        inc_err  = term;
        inc_drop = accept && !fwd;
        o_sop    = in_sop && !term;
        o_eop    = in_eop || term;
        o_empty  = term ? '0 : in_empty;
        o_err    = term;
        good_d   = cnt_clear ? '0 : (inc_good && !(&good_q)) ? good_q + 1'b1 : good_q;
        err_d    = cnt_clear ? '0 : (inc_err  && !(&err_q))  ? err_q  + 1'b1 : err_q;
        drop_d   = cnt_clear ? '0 : (inc_drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    end

    avalon_st_pipe_reg #(.WIDTH(PW)) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (fwd),
        .in_ready   (in_ready),
        .in_payload ({o_sop, o_eop, o_empty, o_err, in_data}),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(pipe_out)
    );

    assign {out_sop, out_eop, out_empty, out_error, out_data} = pipe_out;
    assign cnt_good = good_q;
    assign cnt_err  = err_q;
    assign cnt_drop = drop_q;

endmodule

// File: tb/tb_avalon_st_frame_guard.sv
// tb_avalon_st_frame_guard: scoreboard bench for the frame guard; expected beats queued at drive time
module tb_avalon_st_frame_guard;

    localparam int DW = 32;
    localparam int EW = 6;
    localparam int MB = 150;
    localparam int CW = 10;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic [EW-1:0] em;
        logic          er;
    } beat_t;

    logic          clk = 0;
    logic          rst = 1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 0, in_sop = 0, in_eop = 0;
    logic [EW-1:0] in_empty = '0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_sop, out_eop, out_error;
    logic [EW-1:0] out_empty;
    logic          out_ready = 1;
    logic          cnt_clear = 0;
    logic [CW-1:0] cnt_good, cnt_err, cnt_drop;

    int    checks = 0;
    int    failures = 0;
    bit    rand_rdy = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    avalon_st_frame_guard #(
        .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .MAX_BEATS(MB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_error(out_error), .out_ready(out_ready),
        .cnt_clear(cnt_clear), .cnt_good(cnt_good), .cnt_err(cnt_err), .cnt_drop(cnt_drop)
    );

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // scoreboard: every output transfer must match the oldest queued expectation
    initial begin
        beat_t b, got;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                got = {out_data, out_sop, out_eop, out_empty, out_error};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got=%h", got);
                end else begin
                    b = exp_q.pop_front();
                    if (got !== b) begin
                        failures++;
                        $display("FAIL beat got d=%h s=%b e=%b em=%0d er=%b want d=%h s=%b e=%b em=%0d er=%b",
                                 got.d, got.s, got.e, got.em, got.er, b.d, b.s, b.e, b.em, b.er);
                    end
                end
            end
        end
    end

    function automatic void expect_beat(input logic [DW-1:0] d, input logic s, input logic e,
                                        input logic [EW-1:0] em, input logic er);
        exp_q.push_back({d, s, e, em, er});
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] em);
        bit ok = 0;
        int n = 0;
        in_data = d; in_sop = s; in_eop = e; in_empty = em; in_valid = 1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
        in_valid = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            failures++;
            $display("FAIL drain_%s pending=%0d want 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_cnt();
        cnt_clear = 1;
        @(posedge clk);
        #1;
        cnt_clear = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, out_error, out_empty, out_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h want 0", out_valid, out_data);
        end
        checks++;
        if ({cnt_good, cnt_err, cnt_drop} !== '0) begin
            failures++;
            $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", cnt_good, cnt_err, cnt_drop);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        expect_beat(32'hA0000001, 1, 0, 0, 0);
        expect_beat(32'hA0000002, 0, 0, 0, 0);
        expect_beat(32'hA0000003, 0, 1, 5, 0);
        send(32'hA0000001, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA0000001 || out_sop !== 1'b1) begin
            failures++;
            $display("FAIL basic_latency got v=%b d=%h want v=1 d=a0000001", out_valid, out_data);
        end
        send(32'hA0000002, 0, 0, 0);
        send(32'hA0000003, 0, 1, 5);
        drain("basic");
        checks++;
        if (cnt_good !== 1 || cnt_err !== 0 || cnt_drop !== 0) begin
            failures++;
            $display("FAIL basic_counters got %0d/%0d/%0d want 1/0/0", cnt_good, cnt_err, cnt_drop);
        end
    endtask

    task automatic test_drop_orphan();
        clear_cnt();
        send(32'hB0000001, 0, 0, 0);
        send(32'hB0000002, 0, 1, 0);
        expect_beat(32'hB0000003, 1, 1, 7, 0);
        send(32'hB0000003, 1, 1, 7);
        drain("orphan");
        checks++;
        if (cnt_good !== 1 || cnt_err !== 0 || cnt_drop !== 2) begin
            failures++;
            $display("FAIL orphan_counters got %0d/%0d/%0d want 1/0/2", cnt_good, cnt_err, cnt_drop);
        end
    endtask

    task automatic test_long_frame();
        clear_cnt();
        for (int i = 1; i <= 200; i++) begin
            if (i < MB) expect_beat(DW'(32'hC000_0000 + i), i == 1, 0, 0, 0);
            else if (i == MB) expect_beat(DW'(32'hC000_0000 + i), 0, 1, 0, 1);
            send(DW'(32'hC000_0000 + i), i == 1, i == 200, (i == 200) ? 6'd3 : 6'd0);
        end
        drain("long");
        checks++;
        if (cnt_good !== 0 || cnt_err !== 1 || cnt_drop !== 50) begin
            failures++;
            $display("FAIL long_counters got %0d/%0d/%0d want 0/1/50", cnt_good, cnt_err, cnt_drop);
        end
    endtask

    task automatic test_sop_mid_frame();
        clear_cnt();
        expect_beat(32'hD0000001, 1, 0, 0, 0);
        expect_beat(32'hD0000002, 0, 0, 0, 0);
        expect_beat(32'hD0000003, 0, 1, 0, 1);
        send(32'hD0000001, 1, 0, 0);
        send(32'hD0000002, 0, 0, 0);
        send(32'hD0000003, 1, 0, 9);
        send(32'hD0000004, 0, 1, 2);
        drain("sop_mid");
        checks++;
        if (cnt_good !== 0 || cnt_err !== 1 || cnt_drop !== 1) begin
            failures++;
            $display("FAIL sop_mid_counters got %0d/%0d/%0d want 0/1/1", cnt_good, cnt_err, cnt_drop);
        end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 0;
        send(32'hE0000001, 1, 0, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_flush got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1;
        send(32'hE0000002, 0, 1, 0);
        expect_beat(32'hE0000003, 1, 1, 1, 0);
        send(32'hE0000003, 1, 1, 1);
        drain("reset_mid");
        checks++;
        if (cnt_good !== 1 || cnt_err !== 0 || cnt_drop !== 1) begin
            failures++;
            $display("FAIL reset_mid_counters got %0d/%0d/%0d want 1/0/1", cnt_good, cnt_err, cnt_drop);
        end
    endtask

    task automatic test_clear_coincident();
        clear_cnt();
        expect_beat(32'hF0000001, 1, 1, 0, 0);
        send(32'hF0000001, 1, 1, 0);
        checks++;
        if (cnt_good !== 1) begin
            failures++;
            $display("FAIL clear_pre got %0d want 1", cnt_good);
        end
        expect_beat(32'hF0000002, 1, 0, 0, 0);
        expect_beat(32'hF0000003, 0, 1, 4, 0);
        send(32'hF0000002, 1, 0, 0);
        cnt_clear = 1;
        send(32'hF0000003, 0, 1, 4);
        cnt_clear = 0;
        drain("clear");
        checks++;
        if (cnt_good !== 0 || cnt_err !== 0 || cnt_drop !== 0) begin
            failures++;
            $display("FAIL clear_coincident got %0d/%0d/%0d want 0/0/0", cnt_good, cnt_err, cnt_drop);
        end
    endtask

    task automatic test_random_frames();
        logic [DW-1:0] d;
        int len;
        clear_cnt();
        rand_rdy = 1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                logic [EW-1:0] em;
                d  = $urandom;
                em = (i == len - 1) ? EW'($urandom_range(0, 63)) : '0;
                expect_beat(d, i == 0, i == len - 1, em, 0);
                send(d, i == 0, i == len - 1, em);
                if ($urandom_range(0, 7) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain("random");
        rand_rdy = 0;
        out_ready = 1;
        checks++;
        if (cnt_good !== 1000 || cnt_err !== 0 || cnt_drop !== 0) begin
            failures++;
            $display("FAIL random_counters got %0d/%0d/%0d want 1000/0/0", cnt_good, cnt_err, cnt_drop);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 30; i++) begin
            expect_beat(DW'(32'h5A000000 + i), 1, 1, 0, 0);
            send(DW'(32'h5A000000 + i), 1, 1, 0);
            if (i == 22) begin
                checks++;
                if (cnt_good !== 10'h3FF) begin
                    failures++;
                    $display("FAIL sat_reach got %0d want 1023", cnt_good);
                end
            end
        end
        drain("sat");
        checks++;
        if (cnt_good !== 10'h3FF) begin
            failures++;
            $display("FAIL sat_hold got %0d want 1023", cnt_good);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop_orphan();
        test_long_frame();
        test_sop_mid_frame();
        test_reset_mid_frame();
        test_clear_coincident();
        test_random_frames();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_st_frame_guard.md
AVALON_ST_FRAME_GUARD -- requirements
Module: avalon_st_frame_guard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, beat data width in bits.
REQ-002 SHALL have parameter EMPTY_WIDTH, default 6, width of the empty field.
REQ-003 SHALL have parameter MAX_BEATS, default 150, maximum legal frame length in beats (9600 B / 64 B).
REQ-004 SHALL have parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-005 SHALL have port clk  input  1  sole clock; the block uses one clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-007 SHALL have ports in_data/in_valid/in_sop/in_eop/in_empty  input  DATA_WIDTH/1/1/1/EMPTY_WIDTH  Avalon-ST sink fed from the async FIFO master side.
REQ-008 SHALL have port in_ready  output  1  sink backpressure.
REQ-009 SHALL have ports out_data/out_valid/out_sop/out_eop/out_empty/out_error  output  DATA_WIDTH/1/1/1/EMPTY_WIDTH/1  Avalon-ST source toward 100G TX.
REQ-010 SHALL have port out_ready  input  1  source backpressure.
REQ-011 SHALL have port cnt_clear  input  1  synchronous clear of all counters.
REQ-012 SHALL have ports cnt_good, cnt_err, cnt_drop  output  CNT_WIDTH each  good frames, error-terminated frames, dropped beats.

Function
REQ-013 A beat SHALL transfer on input when in_valid && in_ready and on output when out_valid && out_ready.
REQ-014 Output SHALL be one registered stage; latency input-to-output exactly 1 cycle; in_ready = !out_valid || out_ready (combinational); full throughput under continuous out_ready.
REQ-015 out_* SHALL hold stable while out_valid && !out_ready.
REQ-016 FSM SHALL have states IDLE, IN_FRAME, DROP; evaluated only on accepted input beats.
REQ-017 IDLE, sop=1, eop=1: forward single-beat frame unchanged, cnt_good+1, stay IDLE.
REQ-018 IDLE, sop=1, eop=0: forward, beat count=1, go IN_FRAME.
REQ-019 IDLE, sop=0: drop beat (no output), cnt_drop+1, stay IDLE.
REQ-020 IN_FRAME, sop=0, eop=1: forward, cnt_good+1, go IDLE.
REQ-021 IN_FRAME, sop=0, eop=0, count<MAX_BEATS-1: forward, count+1.
REQ-022 IN_FRAME, sop=0, eop=0, count=MAX_BEATS-1: forward with out_eop=1, out_empty=0, out_error=1, cnt_err+1, go DROP.
REQ-023 IN_FRAME, sop=1 (any eop): forward with out_sop=0, out_eop=1, out_empty=0, out_error=1, cnt_err+1; go IDLE if in_eop=1, else DROP.
REQ-024 DROP: drop every beat, cnt_drop+1 each; on in_eop=1 go IDLE; sop in DROP ignored.
REQ-025 out_error SHALL be 0 on all beats except forced-termination beats in REQ-022/023.
REQ-026 Counters SHALL saturate at all-ones; cnt_clear wins over a simultaneous increment and results in 0.
REQ-027 A frame longer than MAX_BEATS SHALL never reach the output; exactly MAX_BEATS beats are forwarded.

Reset
REQ-028 On rst: state=IDLE, beat count=0, out_valid=0, out_sop=0, out_eop=0, out_error=0, out_empty=0, out_data=0, all counters=0.
REQ-029 rst mid-frame SHALL discard any held output beat; first post-reset beat without sop is dropped per REQ-019.
REQ-030 in_ready SHALL be 1 in the cycle after rst deasserts.

Structure
REQ-031 State encoding (IDLE, IN_FRAME, DROP) and the default MAX_BEATS constant SHALL live in shared package avalon_st_pkg.
REQ-032 Output register with ready/valid SHALL be sub-module avalon_st_pipe_reg; FSM and counters in the top.

Verification
REQ-033 3-beat frame (sop, -, eop, empty=5), out_ready=1 -> identical 3 beats 1 cycle later, empty=5, out_error=0, cnt_good=1.
REQ-034 2 beats without sop then valid 1-beat frame -> only the frame emitted, cnt_drop=2, cnt_good=1.
REQ-035 200-beat frame, MAX_BEATS=150 -> 150 beats out, beat 150 eop=1 error=1, cnt_err=1, cnt_drop=50.
REQ-036 sop on beat 3 of open frame, that frame 4 beats -> beats 1-3 out with beat 3 eop=1 error=1, beat 4 dropped, cnt_err=1, cnt_drop=1.
REQ-037 Random out_ready (50%) over 1000 legal frames -> output stream equals input, no loss or duplication, cnt_good=1000.
REQ-038 cnt_clear coincident with good-frame eop, and counter preset near saturation -> counter 0 after clear, holds all-ones at saturation.
